// File: rtl/manchester_rx_pkg.sv
// Shared protocol constants for the Manchester receive path: frame layout,
// field positions, error-flag bit indices and the receiver FSM state type.
package manchester_rx_pkg;

  localparam int FRAME_BITS = 36;
  localparam int NUM_PAIRS  = 12;  // mode(2) + type(2) + payload(8)
  localparam int NUM_FLAGS  = 5;

  localparam logic [5:0] PREAMBLE = 6'b101010;
  localparam logic [3:0] TRAILER  = 4'b0101;

  // Bit positions inside the 36-bit frame (bit 35 is received first)
  localparam int PRE_MSB     = 35;
  localparam int PRE_LSB     = 30;
  localparam int MODE_MSB    = 29;
  localparam int TYPE_MSB    = 25;
  localparam int PAYLOAD_MSB = 21;
  localparam int PARITY_MSB  = 5;
  localparam int PARITY_LSB  = 4;
  localparam int TRAILER_MSB = 3;
  localparam int TRAILER_LSB = 0;

  // errFlags = {mismatch, trailer, parity, manchester, preamble}
  localparam int FLAG_PREAMBLE = 0;
  localparam int FLAG_MANCH    = 1;
  localparam int FLAG_PARITY   = 2;
  localparam int FLAG_TRAILER  = 3;
  localparam int FLAG_MISMATCH = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARM    = 3'd1,
    HUNT   = 3'd2,
    SAMPLE = 3'd3,
    CHECK  = 3'd4
  } state_t;

  // Parity pair as the transmitter sends it: {xnor-reduce, xor-reduce}
  function automatic logic [1:0] parity_pair(input logic [7:0] payload);
    return {~^payload, ^payload};
  endfunction

endpackage

// File: rtl/manchester_rx_pair_dec.sv
// Single Manchester pair decoder: 01 -> 1, 10 -> 0, 00/11 flagged invalid.
module manchester_pair_dec (
  input  logic [1:0] pair,
  output logic       data,
  output logic       invalid
);

  // A valid pair always has a mid-bit transition, so the second half is the bit
  assign data    = pair[0];
  assign invalid = pair[1] ~^ pair[0];

endmodule

// File: rtl/manchester_rx.sv
// Manchester frame receiver: synchronizes the raw line, finds the frame start
// edge, samples 36 line bits at mid-bit, then validates the whole frame in a
// single CHECK cycle and reports an accept or reject pulse.
// 'program' and 'type' are reserved words in SystemVerilog, so those two
// inputs are named prog and typ.
module manchester_rx #(
  parameter int BIT_CYCLES  = 200000,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       swiptAlive,
  input  logic [1:0] prog,
  input  logic       readDataIn,
  input  logic       din,
  input  logic [1:0] mode,
  input  logic [1:0] typ,
  output logic [7:0] dataIn,
  output logic       dataInReady,
  output logic       frameErr,
  output logic [4:0] errFlags,
  output logic       checkSumBit
);
  import manchester_rx_pkg::*;

  localparam int CNT_W = $clog2(BIT_CYCLES);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(BIT_CYCLES / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(BIT_CYCLES - 1);
  localparam logic [5:0]       LAST_BIT  = 6'(FRAME_BITS - 1);

  logic                   blk_rst;
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   din_s;
  logic                   din_prev_reg;
  state_t                 state_reg;
  logic [CNT_W-1:0]       cnt_reg;
  logic [5:0]             bit_cnt_reg;
  logic [FRAME_BITS-1:0]  shift_reg;
  logic [NUM_PAIRS-1:0]   dec_bits;
  logic [NUM_PAIRS-1:0]   dec_inv;
  logic [1:0]             mode_dec;
  logic [1:0]             type_dec;
  logic [7:0]             payload_dec;
  logic [NUM_FLAGS-1:0]   flags_next;

  assign blk_rst = ~nrst | ~swiptAlive | (prog != 2'b11);

  // Input synchronizer chain; stage 0 takes the raw comparator output
  always_ff @(posedge clk) begin
    if (blk_rst) begin
      sync_reg <= '0;
    end else begin
      sync_reg[0] <= din;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_reg[i] <= sync_reg[i-1];
      end
    end
  end

  assign din_s = sync_reg[SYNC_STAGES-1];

  // Pair gi covers frame bits MODE_MSB-2*gi downto MODE_MSB-2*gi-1;
  // pair 0 is the first one on the line, so it lands in the top decoded bit
  generate
    for (genvar gi = 0; gi < NUM_PAIRS; gi++) begin : g_pair
      manchester_pair_dec u_dec (
        .pair    (shift_reg[MODE_MSB-2*gi -: 2]),
        .data    (dec_bits[NUM_PAIRS-1-gi]),
        .invalid (dec_inv[NUM_PAIRS-1-gi])
      );
    end
  endgenerate

  assign mode_dec    = dec_bits[11:10];
  assign type_dec    = dec_bits[9:8];
  assign payload_dec = dec_bits[7:0];

  // All frame checks evaluated side by side from the captured frame
  always_comb begin
    flags_next = '0;
    flags_next[FLAG_PREAMBLE] = shift_reg[PRE_MSB:PRE_LSB] != PREAMBLE;
    flags_next[FLAG_MANCH]    = |dec_inv;
    flags_next[FLAG_PARITY]   = shift_reg[PARITY_MSB:PARITY_LSB] != parity_pair(payload_dec);
    flags_next[FLAG_TRAILER]  = shift_reg[TRAILER_MSB:TRAILER_LSB] != TRAILER;
    flags_next[FLAG_MISMATCH] = {mode_dec, type_dec} != {mode, typ};
  end

  // Receiver FSM with bit timing, frame capture and registered result outputs
  always_ff @(posedge clk) begin
    if (blk_rst) begin
      state_reg    <= IDLE;
      din_prev_reg <= 1'b0;
      cnt_reg      <= '0;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      dataIn       <= 8'h00;
      dataInReady  <= 1'b0;
      frameErr     <= 1'b0;
      errFlags     <= 5'b0;
      checkSumBit  <= 1'b0;
    end else begin
      dataInReady  <= 1'b0;
      frameErr     <= 1'b0;
      din_prev_reg <= din_s;
      if (!readDataIn) begin
        // Window closed: drop whatever was in flight without reporting it
        state_reg   <= IDLE;
        cnt_reg     <= '0;
        bit_cnt_reg <= '0;
      end else begin
        case (state_reg)
          IDLE: state_reg <= ARM;
          // Whole chain low, so a freshly cleared synchronizer cannot
          // masquerade as an idle line while din is actually held high
          ARM: if (~|sync_reg) state_reg <= HUNT;
          HUNT: begin
            if (din_s && !din_prev_reg) begin
              state_reg   <= SAMPLE;
              cnt_reg     <= HALF_LOAD;
              bit_cnt_reg <= '0;
            end
          end
          SAMPLE: begin
            if (cnt_reg == '0) begin
              shift_reg   <= {shift_reg[FRAME_BITS-2:0], din_s};
              cnt_reg     <= FULL_LOAD;
              bit_cnt_reg <= bit_cnt_reg + 6'd1;
              if (bit_cnt_reg == LAST_BIT) state_reg <= CHECK;
            end else begin
              cnt_reg <= cnt_reg - 1'b1;
            end
          end
          CHECK: begin
            errFlags    <= flags_next;
            checkSumBit <= ~flags_next[FLAG_PARITY];
            if (flags_next == '0) begin
              dataIn      <= payload_dec;
              dataInReady <= 1'b1;
            end else begin
              frameErr <= 1'b1;
            end
            bit_cnt_reg <= '0;
            state_reg   <= ARM;
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_manchester_rx.sv
// Self-checking bench for manchester_rx: frames are built bit by bit, the
// expected outcome of each frame is queued before it is driven and the
// monitor compares every accept/reject pulse against the queue head.
module tb_manchester_rx;
  import manchester_rx_pkg::*;

  localparam int BC = 10;

  logic       clk = 1'b0;
  logic       nrst, swiptAlive, readDataIn, din;
  logic [1:0] prog, mode, typ;
  logic [7:0] dataIn;
  logic       dataInReady, frameErr, checkSumBit;
  logic [4:0] errFlags;

  always #5 clk = ~clk;

  manchester_rx #(.BIT_CYCLES(BC), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .nrst        (nrst),
    .swiptAlive  (swiptAlive),
    .prog        (prog),
    .readDataIn  (readDataIn),
    .din         (din),
    .mode        (mode),
    .typ         (typ),
    .dataIn      (dataIn),
    .dataInReady (dataInReady),
    .frameErr    (frameErr),
    .errFlags    (errFlags),
    .checkSumBit (checkSumBit)
  );

  typedef struct {
    logic       ok;
    logic [7:0] data;
    logic [4:0] flags;
    logic [4:0] mask;
    logic       chk_csb;
    logic       csb;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] last_data = 8'h00;

  function automatic logic [1:0] man(input logic b);
    return b ? 2'b01 : 2'b10;
  endfunction

  function automatic logic [35:0] build(input logic [1:0] m, input logic [1:0] t,
                                        input logic [7:0] p);
    logic [35:0] f;
    f[35:30] = 6'b101010;
    f[29:28] = man(m[1]);
    f[27:26] = man(m[0]);
    f[25:24] = man(t[1]);
    f[23:22] = man(t[0]);
    for (int i = 0; i < 8; i++) f[21-2*i -: 2] = man(p[7-i]);
    f[5]     = ~^p;
    f[4]     = ^p;
    f[3:0]   = 4'b0101;
    return f;
  endfunction

  task automatic expect_ok(input logic [7:0] d);
    exp_t e;
    e = '{1'b1, d, 5'b00000, 5'b11111, 1'b1, 1'b1};
    sb.push_back(e);
    last_data = d;
  endtask

  task automatic expect_err(input logic [4:0] fl, input logic [4:0] mk,
                            input logic chk, input logic csb);
    exp_t e;
    e = '{1'b0, last_data, fl, mk, chk, csb};
    sb.push_back(e);
  endtask

  // Line low for a few cycles, then the first n bits of f, MSB first
  task automatic send_bits(input logic [35:0] f, input int n);
    din = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 35; i > 35 - n; i--) begin
      din = f[i];
      repeat (BC) @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [35:0] f);
    send_bits(f, 36);
    din = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout pending=%0d required=0", name, sb.size());
      sb.delete();
    end
  endtask

  // Scoreboard monitor: every pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (dataInReady || frameErr) begin
      checks++;
      if (dataInReady && frameErr) begin
        errors++;
        $display("FAIL pulse_exclusive ready=1 err=1 required=one_of");
      end
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse ready=%0b err=%0b required=none", dataInReady, frameErr);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checks++;
        if (dataInReady !== e.ok) begin
          errors++;
          $display("FAIL pulse_kind ready=%0b required=%0b", dataInReady, e.ok);
        end
        checks++;
        if (dataIn !== e.data) begin
          errors++;
          $display("FAIL dataIn got=%h required=%h", dataIn, e.data);
        end
        checks++;
        if ((errFlags & e.mask) !== (e.flags & e.mask)) begin
          errors++;
          $display("FAIL errFlags got=%b required=%b mask=%b", errFlags, e.flags, e.mask);
        end
        if (e.chk_csb) begin
          checks++;
          if (checkSumBit !== e.csb) begin
            errors++;
            $display("FAIL checkSumBit got=%b required=%b", checkSumBit, e.csb);
          end
        end
        $display("frame: ready=%0b err=%0b dataIn=%h errFlags=%b csb=%0b",
                 dataInReady, frameErr, dataIn, errFlags, checkSumBit);
      end
    end
  end

  task automatic test_reset();
    nrst = 1'b0; swiptAlive = 1'b1; prog = 2'b11; readDataIn = 1'b0;
    din = 1'b0; mode = 2'b11; typ = 2'b01;
    repeat (4) @(negedge clk);
    checks++; if (dataIn !== 8'h00) begin errors++; $display("FAIL reset_dataIn got=%h required=00", dataIn); end
    checks++; if (dataInReady !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b required=0", dataInReady); end
    checks++; if (frameErr !== 1'b0) begin errors++; $display("FAIL reset_frameErr got=%b required=0", frameErr); end
    checks++; if (errFlags !== 5'b0) begin errors++; $display("FAIL reset_errFlags got=%b required=00000", errFlags); end
    checks++; if (checkSumBit !== 1'b0) begin errors++; $display("FAIL reset_csb got=%b required=0", checkSumBit); end
    checks++; if (dut.state_reg !== IDLE) begin errors++; $display("FAIL reset_state got=%0d required=%0d", dut.state_reg, IDLE); end
    nrst = 1'b1;
    readDataIn = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_valid();
    expect_ok(8'hA5);
    send_frame(build(2'b11, 2'b01, 8'hA5));
    wait_done("valid");
  endtask

  task automatic test_parity();
    logic [35:0] f;
    f = build(2'b11, 2'b01, 8'hA5);
    f[5:4] = ~f[5:4];
    expect_err(5'b00100, 5'b11111, 1'b1, 1'b0);
    send_frame(f);
    wait_done("parity");
  endtask

  task automatic test_manchester();
    logic [35:0] f;
    f = build(2'b11, 2'b01, 8'hA5);
    f[15:14] = 2'b11;
    expect_err(5'b00010, 5'b00010, 1'b0, 1'b0);
    send_frame(f);
    wait_done("manchester");
  endtask

  task automatic test_mismatch();
    typ = 2'b10;
    expect_err(5'b10000, 5'b11111, 1'b1, 1'b1);
    send_frame(build(2'b11, 2'b01, 8'hA5));
    wait_done("mismatch");
    typ = 2'b01;
  endtask

  task automatic test_program_reset();
    send_bits(build(2'b11, 2'b01, 8'h77), 25);
    prog = 2'b01;
    din  = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (dataIn !== 8'h00) begin errors++; $display("FAIL prog_dataIn got=%h required=00", dataIn); end
    checks++; if (errFlags !== 5'b0) begin errors++; $display("FAIL prog_errFlags got=%b required=00000", errFlags); end
    checks++; if (checkSumBit !== 1'b0) begin errors++; $display("FAIL prog_csb got=%b required=0", checkSumBit); end
    checks++; if (dut.state_reg !== IDLE) begin errors++; $display("FAIL prog_state got=%0d required=%0d", dut.state_reg, IDLE); end
    last_data = 8'h00;
    prog = 2'b11;
    repeat (40) @(negedge clk);
    checks++; if (dut.state_reg !== ARM) begin errors++; $display("FAIL held_high_state got=%0d required=%0d", dut.state_reg, ARM); end
    expect_ok(8'h3C);
    send_frame(build(2'b11, 2'b01, 8'h3C));
    wait_done("after_prog");
  endtask

  task automatic test_abort();
    send_bits(build(2'b11, 2'b01, 8'hC3), 20);
    readDataIn = 1'b0;
    @(negedge clk);
    checks++; if (dut.state_reg !== IDLE) begin errors++; $display("FAIL abort_state got=%0d required=%0d", dut.state_reg, IDLE); end
    din = 1'b0;
    repeat (30) @(negedge clk);
    readDataIn = 1'b1;
    expect_ok(8'h96);
    send_frame(build(2'b11, 2'b01, 8'h96));
    wait_done("after_abort");
  endtask

  task automatic test_back_to_back();
    mode = 2'b00; typ = 2'b10;
    expect_ok(8'h00);
    send_frame(build(2'b00, 2'b10, 8'h00));
    expect_ok(8'h01);
    send_frame(build(2'b00, 2'b10, 8'h01));
    wait_done("back_to_back");
    mode = 2'b11; typ = 2'b01;
  endtask

  task automatic test_preamble_trailer();
    logic [35:0] f;
    f = build(2'b11, 2'b01, 8'h5A);
    f[33] = ~f[33];
    f[0]  = ~f[0];
    expect_err(5'b01001, 5'b11111, 1'b1, 1'b1);
    send_frame(f);
    wait_done("preamble_trailer");
  endtask

  initial begin
    test_reset();
    test_valid();
    test_parity();
    test_manchester();
    test_mismatch();
    test_program_reset();
    test_abort();
    test_back_to_back();
    test_preamble_trailer();
    repeat (20) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog time_limit reached required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/manchester_rx.md
MANCHESTER_RX -- requirements
Module: manchester_rx

Interface
REQ-001 Parameter BIT_CYCLES, default 200000, SHALL set the clock cycles per line bit (2 ms at 100 MHz, same as the TX write period).
REQ-002 Parameter SYNC_STAGES, default 2, SHALL set the input synchronizer depth.
REQ-003 Port list, one per line:
  clk          in   1  system clock; all logic on rising edge
  nrst         in   1  reset, synchronous, active-low
  swiptAlive   in   1  link alive; low acts as reset
  program      in   2  program select; only 2'b11 enables the block
  readDataIn   in   1  receive window enable from Data
  din          in   1  raw line bit from ReadData comparator
  mode         in   2  expected mode echo
  type         in   2  expected type echo
  dataIn       out  8  last accepted payload
  dataInReady  out  1  one-cycle pulse: frame accepted
  frameErr     out  1  one-cycle pulse: frame rejected
  errFlags     out  5  {mismatch, trailer, parity, manchester, preamble} of last frame
  checkSumBit  out  1  parity-pair result of last frame, 1 = pass

Function
REQ-004 Frame SHALL be 36 line bits, MSB first: preamble 101010, mode as 2 Manchester pairs, type as 2 Manchester pairs, payload as 8 Manchester pairs, parity pair {~^payload, ^payload}, trailer 0101.
REQ-005 Manchester pair 01 SHALL decode to 1 and 10 to 0; pairs 00 and 11 SHALL set the manchester flag.
REQ-006 din SHALL pass through SYNC_STAGES flip-flops before any use.
REQ-007 FSM states SHALL be IDLE, ARM, HUNT, SAMPLE, CHECK.
REQ-008 IDLE -> ARM when readDataIn = 1; any state -> IDLE in the cycle after readDataIn = 0, with no pulse issued.
REQ-009 ARM -> HUNT once synced din = 0 (line idle); HUNT -> SAMPLE on synced din 0->1.
REQ-010 On entering SAMPLE the bit counter SHALL load BIT_CYCLES/2-1; on reaching 0 the synced din SHALL be shifted into a 36-bit register and the counter reloaded with BIT_CYCLES-1.
REQ-011 After the 36th sample the FSM SHALL go to CHECK for exactly one cycle, then to ARM.
REQ-012 In CHECK all five flags SHALL be evaluated in parallel. preamble: bits 35:30 != 101010. trailer: bits 3:0 != 0101. parity: the received pair != the pair computed from the decoded payload. mismatch: decoded mode/type != the mode/type inputs.
REQ-013 In CHECK, if all flags are 0: dataIn <= decoded payload, dataInReady pulses in the following cycle. Otherwise: frameErr pulses, and dataIn is held.
REQ-014 errFlags and checkSumBit SHALL update in CHECK on every frame and hold until the next CHECK or reset.
REQ-015 Latency SHALL be 2 cycles from the 36th sample to the dataInReady/frameErr pulse; the two pulses SHALL be mutually exclusive.
REQ-016 Edges on din during SAMPLE SHALL be ignored; there is no resync mid-frame.
REQ-017 A new frame SHALL NOT be captured until the line has returned to 0 (via ARM).

Reset
REQ-018 Reset SHALL be applied when ~nrst | ~swiptAlive | (program != 2'b11), sampled on clk.
REQ-019 Reset values: state IDLE, counters 0, shift register 0, synchronizer 0, dataIn 8'h00, dataInReady 0, frameErr 0, errFlags 5'b0, checkSumBit 0.
REQ-020 Reset during SAMPLE or CHECK SHALL abort the frame with no pulse issued.

Structure
REQ-021 Frame constants SHALL live in the shared protocol package: PREAMBLE 6'b101010, TRAILER 4'b0101, FRAME_BITS 36, the field bit positions, and the flag bit indices.
REQ-022 One sub-module, manchester_pair_dec, SHALL be used: 2-bit pair in, decoded bit plus invalid flag out, instantiated 12 times.

Verification (BIT_CYCLES = 10)
REQ-023 Valid frame, mode 2'b11, type 2'b01, payload 8'hA5, expected inputs matching -> dataInReady pulses once, dataIn = 8'hA5, errFlags = 0, checkSumBit = 1.
REQ-024 Same frame with parity pair inverted -> frameErr pulses, errFlags = 5'b00100, checkSumBit = 0, dataIn unchanged.
REQ-025 Payload pair 3 sent as 11 -> errFlags[1] = 1, frameErr pulses.
REQ-026 Frame with type 2'b01 while input type = 2'b10 -> errFlags = 5'b10000, no dataInReady.
REQ-027 readDataIn dropped at sample 20 -> FSM in IDLE next cycle, no pulse; a full frame afterwards is accepted normally.
REQ-028 program switched to 2'b01 mid-frame -> all outputs at reset values; din held high at re-enable -> no capture until din goes 0 then 1.
